// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches, PC-tagged FIFO to decode, flush on redirect.
// Defining FETCH_QUEUE_PERF_EN adds saturating stall/flush performance counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned DataW = 32;

    typedef struct packed {
        logic [DataW-1:0] pc;
        logic [DataW-1:0] inst;
    } fetchEntry_t;

    fetchEntry_t      fifoMem [DEPTH];
    fetchEntry_t      headEntry;

    logic [DataW-1:0] fetchPc, fetchPcNext;
    logic [DataW-1:0] inflightPc, inflightPcNext;
    logic [PtrW-1:0]  wrPtr, wrPtrNext;
    logic [PtrW-1:0]  rdPtr, rdPtrNext;
    logic [CntW-1:0]  count, countNext;
    logic [CntW-1:0]  creditUsed;
    logic             inflight, inflightNext;
    logic             drop, dropNext;
    logic             issue, push, pop, instValid;

    // Handshake qualifiers; a redirect voids any same-cycle push or pop
    assign instValid  = (count != '0);
    assign creditUsed = count + CntW'(inflight);
    assign issue      = reset && !halt && !redirect && (creditUsed < CntW'(DEPTH));
    assign push       = mem_rsp_valid && !drop && !redirect;
    assign pop        = instValid && inst_ready && !redirect;

    always_comb begin
        fetchPcNext    = fetchPc;
        inflightPcNext = inflightPc;
        wrPtrNext      = wrPtr;
        rdPtrNext      = rdPtr;
        countNext      = count;
        inflightNext   = inflight;
        dropNext       = drop;

        if (redirect) begin
            fetchPcNext  = redirect_pc;
            wrPtrNext    = '0;
            rdPtrNext    = '0;
            countNext    = '0;
            inflightNext = 1'b0;
            // A response returning this cycle is voided here; only a still-outstanding one needs dropping
            dropNext     = (inflight || drop) && !mem_rsp_valid;
        end else begin
            if (issue) begin
                fetchPcNext    = fetchPc + 32'd1;
                inflightPcNext = fetchPc;
                inflightNext   = 1'b1;
            end else if (mem_rsp_valid && !drop) begin
                inflightNext = 1'b0;
            end

            if (mem_rsp_valid && drop) begin
                dropNext = 1'b0;
            end

            if (push) begin
                wrPtrNext = wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtrNext = rdPtr + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   countNext = count + CntW'(1);
                2'b01:   countNext = count - CntW'(1);
                default: countNext = count;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc    <= RESET_PC;
            inflightPc <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            fetchPc    <= fetchPcNext;
            inflightPc <= inflightPcNext;
            wrPtr      <= wrPtrNext;
            rdPtr      <= rdPtrNext;
            count      <= countNext;
            inflight   <= inflightNext;
            drop       <= dropNext;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= '{pc: inflightPc, inst: mem_rsp_data};
        end
    end

    assign headEntry  = fifoMem[rdPtr];
    assign mem_req    = issue;
    assign mem_addr   = issue ? fetchPc : '0;
    assign inst_valid = instValid;
    assign inst       = instValid ? headEntry.inst : '0;
    assign inst_pc    = instValid ? headEntry.pc : '0;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stallCnt, stallCntNext;
    logic [31:0] flushCnt, flushCntNext;

    // Saturating counters: empty-output cycles and redirects that discard work
    always_comb begin
        stallCntNext = stallCnt;
        flushCntNext = flushCnt;
        if (!instValid && (stallCnt != '1)) begin
            stallCntNext = stallCnt + 32'd1;
        end
        if (redirect && ((count != '0) || inflight) && (flushCnt != '1)) begin
            flushCntNext = flushCnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            stallCnt <= stallCntNext;
            flushCnt <= flushCntNext;
        end
    end

    assign perf_stall_cycles = stallCnt;
    assign perf_flushes      = flushCnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; memory answers every request one cycle later with addr*3.
// Perf-counter checks are compiled in when FETCH_QUEUE_PERF_EN is defined.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
`endif

    int checkCount = 0;
    int errorCount = 0;
    int reqCount;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    // Memory port model: fixed one-cycle response latency
    always @(posedge clk) begin
        mem_rsp_valid <= mem_req;
        mem_rsp_data  <= mem_addr * 32'd3;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req"},   32'(mem_req),    32'd0);
        checkVal({tag, "_addr"},  mem_addr,        32'd0);
        checkVal({tag, "_valid"}, 32'(inst_valid), 32'd0);
        checkVal({tag, "_inst"},  inst,            32'd0);
        checkVal({tag, "_pc"},    inst_pc,         32'd0);
    endtask

    // Called at a falling edge; checks n consecutive delivered instructions
    task automatic expectStream(input logic [31:0] startPc, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = startPc + 32'(i);
            checkVal("stream_valid", 32'(inst_valid), 32'd1);
            checkVal("stream_pc",    inst_pc,         p);
            checkVal("stream_inst",  inst,            p * 32'd3);
            @(negedge clk);
        end
    endtask

    // Redirect, then confirm the two empty cycles before the new stream reaches the head
    task automatic doRedirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        #1;
        checkVal("redir_req_blocked", 32'(mem_req), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checkVal("redir_flushed", 32'(inst_valid), 32'd0);
        checkVal("redir_req",     32'(mem_req),    32'd1);
        checkVal("redir_addr",    mem_addr,        pc);
        @(negedge clk);
        checkVal("redir_empty", 32'(inst_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("rst");

        // Startup: first request right after release, first instruction two cycles later
        reset = 1'b1;
        #1;
        checkVal("start_req",   32'(mem_req),    32'd1);
        checkVal("start_addr",  mem_addr,        32'd0);
        checkVal("start_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkVal("c1_valid", 32'(inst_valid), 32'd0);
        checkVal("c1_addr",  mem_addr,        32'd1);
        @(negedge clk);
        expectStream(32'h0, 6);

        // Asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1;
        checkResetOutputs("async_rst");

        // Restart with decoder stalled: credit limit allows exactly DEPTH requests
        inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("restart_req",  32'(mem_req), 32'd1);
        checkVal("restart_addr", mem_addr,     32'h0);
        reqCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) reqCount++;
            @(negedge clk);
        end
        checkVal("stall_reqs",     32'(reqCount),   32'd4);
        checkVal("stall_req_off",  32'(mem_req),    32'd0);
        checkVal("stall_head_pc",  inst_pc,         32'h0);
        checkVal("stall_valid",    32'(inst_valid), 32'd1);

        // One pop frees a credit; next fetch continues at pc 4
        inst_ready = 1'b1;
        @(negedge clk);
        checkVal("drain_pc",   inst_pc,      32'h1);
        checkVal("drain_req",  32'(mem_req), 32'd1);
        checkVal("drain_addr", mem_addr,     32'h4);
        inst_ready = 1'b0;
        @(negedge clk);
        checkVal("full_pc",  inst_pc,            32'h1);
        checkVal("full_req", 32'(mem_req),       32'd0);
        checkVal("rsp_live", 32'(mem_rsp_valid), 32'd1);

        // Redirect with count=3, one in flight, pop and push both pending this cycle
        inst_ready = 1'b1;
        doRedirect(32'h100);
        expectStream(32'h100, 4);

        // Halt with two entries queued: both delivered, no new fetch until released
        halt       = 1'b1;
        inst_ready = 1'b0;
        #1;
        checkVal("halt_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        inst_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkVal("halt_pc",     inst_pc,      32'h104 + 32'(i));
            checkVal("halt_req_hd", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            checkVal("halt_empty",   32'(inst_valid), 32'd0);
            checkVal("halt_req_emp", 32'(mem_req),    32'd0);
            @(negedge clk);
        end
        halt = 1'b0;
        #1;
        checkVal("resume_req",  32'(mem_req), 32'd1);
        checkVal("resume_addr", mem_addr,     32'h106);
        @(negedge clk);
        checkVal("resume_empty", 32'(inst_valid), 32'd0);
        @(negedge clk);
        expectStream(32'h106, 3);

        // Fetch address wraps through 32'hFFFFFFFF
        doRedirect(32'hFFFF_FFFE);
        expectStream(32'hFFFF_FFFE, 4);

`ifdef FETCH_QUEUE_PERF_EN
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        @(negedge clk);
        checkVal("perf_stall_min", 32'(perf_stall_cycles >= 32'd2), 32'd1);
        doRedirect(32'h200);
        doRedirect(32'h300);
        doRedirect(32'h400);
        checkVal("perf_flushes", perf_flushes, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
